// File: rtl/wb_trace_capture.sv
// wb_trace_capture
//   Trace sink for the writeback observation port. Every change of the WB
//   result (or the first sample after reset/clear) is stamped with a
//   free-running cycle counter and queued in a first-word-fall-through FIFO.
//   A consumer drains the FIFO over a valid/ready read port.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   wb_result   processor writeback result being observed
//   capture_en  1 = sample wb_result this cycle
//   clear       synchronous flush of FIFO and flags; beats push/pop
//   rd_ready    consumer accepts the head entry
//   rd_valid    FIFO non-empty, head entry valid
//   rd_data     head entry result
//   rd_ts       head entry timestamp
//   count       occupancy 0..DEPTH
//   overflow    sticky: at least one capture was dropped
//   drop_count  number of dropped captures, saturating
module wb_trace_capture #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DC_W   = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              capture_en,
  input  logic              clear,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [TS_W-1:0]   rd_ts,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic [DC_W-1:0]   drop_count
);

  // Storage
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TS_W-1:0]   mem_ts   [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Capture tracking
  logic [TS_W-1:0]   ts_cnt;
  logic [DATA_W-1:0] last_val;
  logic              armed;

  // Per-cycle decisions
  logic full_c;
  logic pop_c;
  logic hit_c;
  logic push_c;
  logic drop_c;

  // Head of the FIFO is visible directly from the register array.
  assign rd_valid = (count != '0);
  assign rd_data  = mem_data[rd_ptr];
  assign rd_ts    = mem_ts[rd_ptr];

  // A hit is a sampled value that differs from the previous one, or the
  // first sample after reset/clear. A full FIFO still accepts a hit when
  // the head leaves in the same cycle.
  always_comb begin
    full_c = (count == (AW+1)'(DEPTH));
    pop_c  = rd_valid && rd_ready && !clear;
    hit_c  = capture_en && (armed || (wb_result != last_val));
    push_c = hit_c && !clear && (!full_c || pop_c);
    drop_c = hit_c && !clear && !push_c;
  end

  // Free-running timestamp; only reset touches it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_ts[i]   <= '0;
      end
    end else if (push_c) begin
      mem_data[wr_ptr] <= wb_result;
      mem_ts[wr_ptr]   <= ts_cnt;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Change detector state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_val <= '0;
      armed    <= 1'b1;
    end else if (clear) begin
      armed    <= 1'b1;
    end else if (hit_c) begin
      last_val <= wb_result;
      armed    <= 1'b0;
    end
  end

  // Drop bookkeeping: sticky flag plus saturating counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop_c) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + DC_W'(1);
      end
    end
  end

endmodule
